// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - programmable serial bit-pattern detector with overlap mode and saturating match counter
//
// Purpose:
//   Watches a qualified serial bit stream for a programmable pattern of up to
//   PAT_W bits. Emits a registered single-cycle pulse per match and keeps a
//   saturating count of matches. Overlapping or non-overlapping matching is
//   selectable. Out of reset the block behaves as a two-consecutive-ones
//   detector.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   cfg_load     latch cfg_pattern/cfg_len/cfg_overlap, clear history
//   cfg_pattern  pattern bits, bit [len-1] is received first, bit [0] last
//   cfg_len      pattern length (0/1 -> 1, > PAT_W -> PAT_W)
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   in_valid     qualifies x
//   x            serial data bit
//   count_clr    synchronous clear of match_count
//   z            registered match pulse
//   match_count  saturating match count
//   armed        at least len valid bits seen since the last history clear

module seq_pattern_detector #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             in_valid,
    input  logic             x,
    input  logic             count_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(PAT_W);
    localparam logic [LEN_W:0]   LEN_MAX_X = (LEN_W + 1)'(PAT_W);
    localparam logic [LEN_W-1:0] LEN_RST   = LEN_W'(2);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Ones in the low l bit positions; selects the live part of the pattern.
    function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] l);
        logic [PAT_W-1:0] m;
        m = '0;
        for (int i = 0; i < PAT_W; i++) begin
            m[i] = (i < int'(l));
        end
        return m;
    endfunction

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        logic [LEN_W-1:0] r;
        if (l == '0) begin
            r = LEN_W'(1);
        end else if (int'(l) > PAT_W) begin
            r = LEN_MAX;
        end else begin
            r = l;
        end
        return r;
    endfunction

    // Working configuration
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;

    // Stream state
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] seen_q, seen_d;
    logic             z_q, z_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;

    logic [PAT_W-1:0] hist_shift;
    logic [LEN_W:0]   seen_ext;
    logic [LEN_W-1:0] seen_inc;
    logic [LEN_W-1:0] load_len;
    logic             bits_match;
    logic             hit;
    logic [CNT_W-1:0] cnt_base;

    always_comb begin
        pat_d    = pat_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        hist_d   = hist_q;
        seen_d   = seen_q;
        hit      = 1'b0;

        hist_shift = {hist_q[PAT_W-2:0], x};
        // One extra bit so seen+1 never wraps before it is compared.
        seen_ext   = {1'b0, seen_q} + (LEN_W + 1)'(1);
        seen_inc   = (seen_ext >= LEN_MAX_X) ? LEN_MAX : seen_ext[LEN_W-1:0];
        bits_match = (((hist_shift ^ pat_q) & len_mask(len_q)) == '0);
        load_len   = clamp_len(cfg_len);

        if (cfg_load) begin
            // The sample on a load edge is dropped; the new config takes
            // effect from the next edge. Unused pattern bits are zeroed so
            // they can never carry X into the compare.
            pat_d  = cfg_pattern & len_mask(load_len);
            len_d  = load_len;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            seen_d = '0;
        end else if (in_valid) begin
            hist_d = hist_shift;
            hit    = (seen_ext >= {1'b0, len_q}) && bits_match;
            // Non-overlapping: restart the fresh-bit count but keep history.
            seen_d = (hit && !ovl_q) ? '0 : seen_inc;
        end

        z_d = hit;

        // Clear first, then count the hit, so clear+hit lands on 1.
        cnt_base = count_clr ? '0 : cnt_q;
        cnt_d    = (hit && (cnt_base != CNT_MAX)) ? cnt_base + CNT_W'(1) : cnt_base;

        armed_d = (seen_d >= len_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q   <= '1;
            len_q   <= LEN_RST;
            ovl_q   <= 1'b1;
            hist_q  <= '0;
            seen_q  <= '0;
            z_q     <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            seen_q  <= seen_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign z           = z_q;
    assign match_count = cnt_q;
    assign armed       = armed_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - self-checking bench for seq_pattern_detector against a bit-queue reference model

module tb_seq_pattern_detector;

    localparam int PAT_W = 8;
    localparam int LEN_W = $clog2(PAT_W) + 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic             in_valid = 1'b0;
    logic             x = 1'b0;
    logic             count_clr = 1'b0;

    logic             z, armed, z3, armed3;
    logic [7:0]       match_count;
    logic [2:0]       match_count3;

    int checks   = 0;
    int failures = 0;

    // Reference model state: received bits since last clear, fresh-bit count,
    // working config and the two counters (8-bit and 3-bit wide).
    bit        m_bits[$];
    int        m_fresh;
    int        m_L;
    logic [7:0] m_pat;
    bit        m_ovl;
    int        m_cnt;
    int        m_cnt3;
    bit        m_z;

    seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .x(x),
        .count_clr(count_clr), .z(z), .match_count(match_count), .armed(armed)
    );

    seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .x(x),
        .count_clr(count_clr), .z(z3), .match_count(match_count3), .armed(armed3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_fresh = 0;
        m_L     = 2;
        m_pat   = 8'hFF;
        m_ovl   = 1'b1;
        m_cnt   = 0;
        m_cnt3  = 0;
        m_z     = 1'b0;
    endtask

    task automatic model_step(input bit load, input logic [7:0] pat, input logic [3:0] len,
                              input bit ovl, input bit valid, input bit xb, input bit clr);
        bit hit;
        hit = 1'b0;
        if (load) begin
            m_L   = (len == 0) ? 1 : ((int'(len) > PAT_W) ? PAT_W : int'(len));
            m_pat = pat;
            m_ovl = ovl;
            m_bits.delete();
            m_fresh = 0;
        end else if (valid) begin
            m_bits.push_back(xb);
            if (m_bits.size() > 40) void'(m_bits.pop_front());
            m_fresh++;
            if (m_fresh >= m_L) begin
                hit = 1'b1;
                // Last received bit pairs with pattern bit 0, earlier ones upward.
                for (int i = 0; i < m_L; i++) begin
                    if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 1'b0;
                end
            end
            if (hit && !m_ovl) m_fresh = 0;
        end
        if (clr) begin
            m_cnt  = 0;
            m_cnt3 = 0;
        end
        if (hit) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt3 < 7) m_cnt3++;
        end
        m_z = hit;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".z"},      32'(z),            32'(m_z));
        check({tag, ".count"},  32'(match_count),  32'(m_cnt));
        check({tag, ".armed"},  32'(armed),        32'(m_fresh >= m_L));
        check({tag, ".z3"},     32'(z3),           32'(m_z));
        check({tag, ".count3"}, 32'(match_count3), 32'(m_cnt3));
    endtask

    task automatic cycle(input string tag, input bit load, input logic [7:0] pat,
                         input logic [3:0] len, input bit ovl, input bit valid,
                         input bit xb, input bit clr);
        cfg_load    = load;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        in_valid    = valid;
        x           = xb;
        count_clr   = clr;
        @(posedge clk);
        model_step(load, pat, len, ovl, valid, xb, clr);
        #1;
        check_all(tag);
    endtask

    task automatic send(input string tag, input bit xb);
        cycle(tag, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, xb, 1'b0);
    endtask

    initial begin
        bit s1[6] = '{0, 1, 1, 1, 0, 1};
        bit s2[7] = '{1, 0, 1, 1, 0, 1, 1};
        bit vg[4] = '{1, 0, 0, 1};

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst.z", 32'(z), 32'd0);
        check("rst.count", 32'(match_count), 32'd0);
        check("rst.armed", 32'(armed), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Default config: two consecutive ones
        foreach (s1[i]) send("dflt", s1[i]);
        check("dflt.total", 32'(match_count), 32'd2);

        // 1011 overlapping; load cycle carries valid x=1 which must be dropped
        cycle("ld1011o", 1'b1, 8'b1011, 4'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        foreach (s2[i]) send("p1011o", s2[i]);
        check("p1011o.total", 32'(match_count), 32'd2);

        // 1011 non-overlapping
        cycle("ld1011n", 1'b1, 8'b1011, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        foreach (s2[i]) send("p1011n", s2[i]);
        check("p1011n.total", 32'(match_count), 32'd1);

        // in_valid gaps with pattern 11
        cycle("ld11", 1'b1, 8'b11, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        foreach (vg[i]) cycle("gap", 1'b0, 8'h00, 4'd0, 1'b0, vg[i], 1'b1, 1'b0);
        check("gap.total", 32'(match_count), 32'd1);

        // Saturation of the 3-bit counter under default config
        reset_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) send("sat", 1'b1);
        check("sat.count3", 32'(match_count3), 32'd7);
        check("sat.count", 32'(match_count), 32'd11);
        cycle("clrhit", 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("clrhit.count3", 32'(match_count3), 32'd1);
        cycle("clronly", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clronly.count3", 32'(match_count3), 32'd0);

        // Reset mid-pattern: asynchronous, then finish the stream
        send("pre", 1'b1);
        cycle("ldmid", 1'b1, 8'b1011, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        send("mid", 1'b1);
        send("mid", 1'b0);
        send("mid", 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("async.z", 32'(z), 32'd0);
        check("async.count", 32'(match_count), 32'd0);
        check("async.armed", 32'(armed), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        send("post", 1'b1);
        check("post.z", 32'(z), 32'd0);
        send("post2", 1'b1);
        check("post2.z", 32'(z), 32'd1);

        // cfg_len=0 loads as length 1
        cycle("ldlen0", 1'b1, 8'h01, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        send("len1", 1'b1);
        check("len1.armed", 32'(armed), 32'd1);
        send("len1", 1'b0);
        send("len1", 1'b1);
        send("len1", 1'b1);
        check("len1.total", 32'(match_count), 32'd3);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            bit         ld, vl, xb, cl, ov;
            logic [7:0] pt;
            logic [3:0] ln;
            ld = ($urandom_range(0, 39) == 0);
            vl = ($urandom_range(0, 9) < 8);
            xb = $urandom_range(0, 1);
            cl = ($urandom_range(0, 49) == 0);
            ov = $urandom_range(0, 1);
            pt = 8'($urandom);
            ln = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(1, 4));
            cycle("rand", ld, pt, ln, ov, vl, xb, cl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
- Parametrised serial bit-pattern detector. Generalises the fixed two-consecutive-ones detector to a programmable pattern of up to PAT_W bits.
- Adds a selectable overlap mode, an input qualifier, and a saturating match counter.
- Sits on a serial status/data line. Drives a single-cycle match pulse and a running match count to downstream control logic.

Parameters:
- PAT_W, 8, maximum pattern length in bits; legal range 2 to 32.
- CNT_W, 8, width of the match counter.
- LEN_W, $clog2(PAT_W)+1, width of cfg_len; derived, must not be overridden.

Ports:
- clk  input  1  single clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- cfg_load  input  1  latches cfg_pattern, cfg_len and cfg_overlap into the working config.
- cfg_pattern  input  PAT_W  pattern bits; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  input  LEN_W  pattern length.
- cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
- in_valid  input  1  qualifies x; when low the sample is ignored.
- x  input  1  serial data bit.
- count_clr  input  1  synchronous clear of match_count.
- z  output  1  registered match pulse.
- match_count  output  CNT_W  saturating number of matches.
- armed  output  1  high when at least len valid bits have been received since the last history clear.

Behaviour:
- Reset (async assert, sync release) sets:
  - z=0, match_count=0, history=0, seen=0, armed=0.
  - Working config: pattern=all ones, len=2, overlap=1.
  - Default config reproduces the legacy consecutive-ones detector: z pulses every valid cycle once two consecutive ones have been seen.
- Effective length L = cfg_len clamped: 0 or 1 treated as 1; values > PAT_W treated as PAT_W. Clamping is applied at cfg_load.
- State held:
  - history[PAT_W-1:0]: shift register of received bits, newest at bit 0.
  - seen: count of valid bits since the last clear, saturating at PAT_W.
- Each rising edge with in_valid=1 and cfg_load=0:
  - history <= {history[PAT_W-2:0], x}; seen <= min(seen+1, PAT_W).
  - hit = (seen+1 >= L) and (low L bits of the new history == low L bits of the pattern).
  - z <= hit.
  - If hit and overlap=0: seen <= 0, history is retained. The next match needs L fresh bits.
  - If hit and overlap=1: seen is unchanged apart from the normal increment.
- Edge with in_valid=0: history and seen hold; z <= 0.
- Latency: a bit sampled at edge k that completes the pattern makes z high from edge k to edge k+1 (exactly one cycle per hit).
- cfg_load=1 at an edge:
  - Latches the new config, clears history and seen, and sets z <= 0.
  - The x sample on that edge is discarded even if in_valid=1.
  - The new config is used starting from the next edge.
- match_count:
  - Increments on each hit and saturates at 2^CNT_W-1; it does not wrap.
  - count_clr at the same edge as a hit gives match_count=1 (the hit is counted after the clear).
  - count_clr alone gives 0.
  - cfg_load does not touch match_count.
- armed = (seen >= L), registered form derived from the stored seen and the stored L.
- Reset asserted mid-stream: all state returns to reset values immediately. The partial pattern is lost and no z pulse is generated.
- Internal widths: seen is LEN_W bits; comparisons use the masked low L bits. No X-propagation on unused pattern bits.

Test Plan:
- Default config after reset, in_valid=1, x stream 0,1,1,1,0,1 → z high in the cycles after the 3rd and 4th samples only; match_count=2.
- Load pattern 4'b1011, len=4, overlap=1; stream 1,0,1,1,0,1,1 → z after the 4th and 7th samples; match_count=2.
- Same pattern with overlap=0; stream 1,0,1,1,0,1,1 → z after the 4th sample only, because seen is reset to 0 and only 3 fresh bits follow; match_count=1.
- in_valid gaps: pattern 1,1 (default) with in_valid pattern 1,0,0,1 and x=1 throughout → single z pulse on the cycle after the 4th edge; z=0 during the gap cycles.
- CNT_W=3, default config, x=1 held for 12 valid cycles → match_count saturates at 7. count_clr coincident with a hit → match_count=1. Then count_clr alone → 0.
- Reset mid-pattern (after 1,0,1 of 1011) then finish the stream with 1 → no z pulse; match_count=0, armed=0, config returns to defaults. Also: cfg_len=0 loads as L=1, pattern bit0=1 → z pulses on every valid x=1.
